// File: rtl/dca_matrix_row_drainer_pkg.sv
// -----------------------------------------------------------------------------
// dca_matrix_row_drainer_pkg
//   Shared defaults and width helpers for the DCA matrix row drainer.
//   Default matrix geometry is defined here. row_index_width() gives the width of
//   a row index, and never returns less than one bit.
// -----------------------------------------------------------------------------
package dca_matrix_row_drainer_pkg;

    localparam int unsigned MATRIX_SIZE_DEFAULT      = 8;
    localparam int unsigned BW_TENSOR_SCALAR_DEFAULT = 32;

    // max(1, clog2(n)): a 1x1 matrix still needs a 1-bit index port
    function automatic int unsigned row_index_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dca_matrix_row_drainer.sv
// -----------------------------------------------------------------------------
// dca_matrix_row_drainer
//   Reader side of the DCA matrix register shift port. On start, the block
//   captures the top row of the matrix register and pulses shift_up once per
//   row, for exactly MATRIX_SIZE_PARA pulses. The captured rows stream out on a
//   valid/ready interface at up to one row per cycle.
//
//   Optional feature macro: DCA_ROW_DRAINER_COL_MODE_EN
//     defined   : col_mode port and XPOSE state exist. The register is
//                 transposed before the first capture, so columns drain.
//     undefined : row order only. transpose is tied low.
//
// Ports
//   clk, rstnn           clock (rising edge), async active-low reset
//   start                drain request, sampled only while idle
//   col_mode             column-order drain (macro builds only)
//   clear                synchronous abort; overrides everything except reset
//   busy                 high while a drain is in progress
//   done                 1-cycle pulse on the final row handshake
//   shift_up, transpose  command strobes to the matrix register
//   upmost_rdata_list1d  current top row of the matrix register
//   row_valid/row_ready  output handshake
//   row_data, row_index  captured row and its index
//   row_last             row_valid on the final row
// -----------------------------------------------------------------------------
module dca_matrix_row_drainer
    import dca_matrix_row_drainer_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE_PARA = MATRIX_SIZE_DEFAULT,
    parameter int unsigned BW_TENSOR_SCALAR = BW_TENSOR_SCALAR_DEFAULT,
    localparam int unsigned BW_TENSOR_ROW   = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR,
    localparam int unsigned BW_ROW_INDEX    = row_index_width(MATRIX_SIZE_PARA)
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     start,
`ifdef DCA_ROW_DRAINER_COL_MODE_EN
    input  logic                     col_mode,
`endif
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic                     shift_up,
    output logic                     transpose,
    input  logic [BW_TENSOR_ROW-1:0] upmost_rdata_list1d,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [BW_TENSOR_ROW-1:0] row_data,
    output logic [BW_ROW_INDEX-1:0]  row_index,
    output logic                     row_last
);

    // FSM encoding stays private to this module
`ifdef DCA_ROW_DRAINER_COL_MODE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XPOSE = 2'd1,
        S_LOAD  = 2'd2,
        S_SEND  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd2,
        S_SEND  = 2'd3
    } state_t;
`endif

    localparam logic [BW_ROW_INDEX-1:0] LAST_INDEX = BW_ROW_INDEX'(MATRIX_SIZE_PARA - 1);
    localparam logic [BW_ROW_INDEX-1:0] INDEX_ONE  = BW_ROW_INDEX'(1);

    state_t                     state_q;
    state_t                     state_d;
    logic [BW_TENSOR_ROW-1:0]   row_data_q;
    logic [BW_TENSOR_ROW-1:0]   row_data_d;
    logic [BW_ROW_INDEX-1:0]    row_index_q;
    logic [BW_ROW_INDEX-1:0]    row_index_d;
    logic                       shift_up_c;
    logic                       transpose_c;
    logic                       done_c;
    logic                       is_last_c;

    // State, captured row and row index registers
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= S_IDLE;
            row_data_q  <= '0;
            row_index_q <= '0;
        end else begin
            state_q     <= state_d;
            row_data_q  <= row_data_d;
            row_index_q <= row_index_d;
        end
    end

    assign is_last_c = (row_index_q == LAST_INDEX);

    // Next state, captures, and the shift/transpose/done strobes.
    // The matrix register updates on the same edge that samples upmost_rdata_list1d,
    // so each capture takes the pre-shift top row.
    always_comb begin
        state_d     = state_q;
        row_data_d  = row_data_q;
        row_index_d = row_index_q;
        shift_up_c  = 1'b0;
        transpose_c = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A clear in the same cycle drops the start request
                if (!clear && start) begin
                    row_index_d = '0;
`ifdef DCA_ROW_DRAINER_COL_MODE_EN
                    state_d     = col_mode ? S_XPOSE : S_LOAD;
`else
                    state_d     = S_LOAD;
`endif
                end
            end

`ifdef DCA_ROW_DRAINER_COL_MODE_EN
            S_XPOSE: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else begin
                    transpose_c = 1'b1;
                    state_d     = S_LOAD;
                end
            end
`endif

            S_LOAD: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else begin
                    row_data_d = upmost_rdata_list1d;
                    shift_up_c = 1'b1;
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                if (clear) begin
                    // Abort: the register is left partly shifted and done stays low
                    state_d = S_IDLE;
                end else if (row_ready) begin
                    if (is_last_c) begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Load the next row on the handshake edge, with no bubble cycle
                        row_data_d  = upmost_rdata_list1d;
                        row_index_d = row_index_q + INDEX_ONE;
                        shift_up_c  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign row_valid = (state_q == S_SEND);
    assign row_last  = row_valid && is_last_c;
    assign row_data  = row_data_q;
    assign row_index = row_index_q;
    assign shift_up  = shift_up_c;
    assign done      = done_c;
`ifdef DCA_ROW_DRAINER_COL_MODE_EN
    assign transpose = transpose_c;
`else
    assign transpose = 1'b0;
`endif

endmodule
